mem: RTL and testbench

Memory-access stage of the bexkat1 pipeline: sits between execute and writeback and feeds the writeback stage's `ir_i`/`pc_i`/`ccr_i`/`reg_write_i`/`result_i`/`halt_i`/`pc_set_i` inputs. It passes ALU results through unchanged. For loads and stores it runs one Wishbone classic bus cycle, stalls the upstream pipeline until ack, and emits bubbles downstream while it waits. Big-endian: byte lane at `addr[1:0]=0` is `dat[31:24]`.

---
 rtl/mem.sv | 189 ++++++++++++++++++
 tb/tb_mem.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem.sv
// Memory-access stage of the bexkat1 pipeline: passes ALU results to writeback
// and runs one Wishbone classic cycle per load/store, stalling upstream until ack.
module mem (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] ir_i,
    input  logic [31:0] pc_i,
    input  logic [2:0]  ccr_i,
    input  logic [1:0]  reg_write_i,
    input  logic [31:0] result_i,
    input  logic [31:0] store_data_i,
    input  logic        halt_i,
    input  logic        pc_set_i,
    output logic        stall_o,
    output logic [63:0] ir_o,
    output logic [31:0] pc_o,
    output logic [2:0]  ccr_o,
    output logic [1:0]  reg_write_o,
    output logic [31:0] result_o,
    output logic        halt_o,
    output logic        pc_set_o,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [31:0] bus_adr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_dat_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_t;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    // Big-endian lane selects: lane at address offset 0 is dat[31:24].
    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] sel;
        case (size)
            SZ_HALF: sel = a[1] ? 4'b0011 : 4'b1100;
            SZ_BYTE: sel = 4'b1000 >> a;
            default: sel = 4'b1111;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] store_repl(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            SZ_HALF: r = {d[15:0], d[15:0]};
            SZ_BYTE: r = {4{d[7:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] a,
                                                 input logic [31:0] d);
        logic [31:0] r;
        case (size)
            SZ_HALF: r = a[1] ? {16'h0000, d[15:0]} : {16'h0000, d[31:16]};
            SZ_BYTE: begin
                case (a)
                    2'd0:    r = {24'h000000, d[31:24]};
                    2'd1:    r = {24'h000000, d[23:16]};
                    2'd2:    r = {24'h000000, d[15:8]};
                    default: r = {24'h000000, d[7:0]};
                endcase
            end
            default: r = d;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [63:0] ir_q, ir_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  ccr_q, ccr_d;
    logic [1:0]  reg_write_q, reg_write_d;
    logic [31:0] result_q, result_d;
    logic        halt_q, halt_d;
    logic        pc_set_q, pc_set_d;

    logic        is_load_s;
    logic        is_store_s;
    logic        is_mem_s;
    logic [1:0]  size_s;
    logic [3:0]  sel_s;

    assign is_load_s  = (ir_i[31:28] == 4'h6);
    assign is_store_s = (ir_i[31:28] == 4'h7);
    assign is_mem_s   = is_load_s | is_store_s;
    assign size_s     = ir_i[25:24];
    assign sel_s      = lane_sel(size_s, result_i[1:0]);

    assign bus_adr_o  = {result_i[31:2], 2'b00};
    assign bus_dat_o  = store_repl(size_s, store_data_i);

    // Next state, stall, bus strobes and next output values.
    always_comb begin
        state_d     = state_q;
        stall_o     = 1'b0;
        bus_cyc_o   = 1'b0;
        bus_stb_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_sel_o   = 4'b0000;
        // Bubble by default; pc/ccr/result still track the inputs.
        ir_d        = 64'h0;
        reg_write_d = 2'b00;
        halt_d      = 1'b0;
        pc_set_d    = 1'b0;
        pc_d        = pc_i;
        ccr_d       = ccr_i;
        result_d    = result_i;
        case (state_q)
            ST_IDLE: begin
                if (is_mem_s) begin
                    stall_o = 1'b1;
                    state_d = ST_BUS;
                end else begin
                    ir_d        = ir_i;
                    reg_write_d = reg_write_i;
                    halt_d      = halt_i;
                    pc_set_d    = pc_set_i;
                end
            end
            ST_BUS: begin
                bus_cyc_o = 1'b1;
                bus_stb_o = 1'b1;
                bus_we_o  = is_store_s;
                bus_sel_o = sel_s;
                if (bus_ack_i) begin
                    state_d  = ST_IDLE;
                    ir_d     = ir_i;
                    halt_d   = halt_i;
                    pc_set_d = pc_set_i;
                    if (is_load_s) begin
                        reg_write_d = reg_write_i;
                        result_d    = load_extract(size_s, result_i[1:0], bus_dat_i);
                    end else begin
                        reg_write_d = 2'b00;
                    end
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and writeback-facing output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            ir_q        <= 64'h0;
            pc_q        <= 32'h0;
            ccr_q       <= 3'b000;
            reg_write_q <= 2'b00;
            result_q    <= 32'h0;
            halt_q      <= 1'b0;
            pc_set_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            pc_q        <= pc_d;
            ccr_q       <= ccr_d;
            reg_write_q <= reg_write_d;
            result_q    <= result_d;
            halt_q      <= halt_d;
            pc_set_q    <= pc_set_d;
        end
    end

    assign ir_o        = ir_q;
    assign pc_o        = pc_q;
    assign ccr_o       = ccr_q;
    assign reg_write_o = reg_write_q;
    assign result_o    = result_q;
    assign halt_o      = halt_q;
    assign pc_set_o    = pc_set_q;

endmodule

// File: tb/tb_mem.sv
// Scoreboard bench for the mem stage: stimulus pushes expected completions,
// a negedge monitor pops and compares every non-bubble output.
module tb_mem;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [63:0] ir_i;
    logic [31:0] pc_i;
    logic [2:0]  ccr_i;
    logic [1:0]  reg_write_i;
    logic [31:0] result_i;
    logic [31:0] store_data_i;
    logic        halt_i;
    logic        pc_set_i;
    logic        stall_o;
    logic [63:0] ir_o;
    logic [31:0] pc_o;
    logic [2:0]  ccr_o;
    logic [1:0]  reg_write_o;
    logic [31:0] result_o;
    logic        halt_o;
    logic        pc_set_o;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [31:0] bus_adr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_dat_o;
    logic [31:0] bus_dat_i;
    logic        bus_ack_i;

    mem dut (
        .clk_i(clk_i), .rst_i(rst_i), .ir_i(ir_i), .pc_i(pc_i), .ccr_i(ccr_i),
        .reg_write_i(reg_write_i), .result_i(result_i), .store_data_i(store_data_i),
        .halt_i(halt_i), .pc_set_i(pc_set_i), .stall_o(stall_o), .ir_o(ir_o),
        .pc_o(pc_o), .ccr_o(ccr_o), .reg_write_o(reg_write_o), .result_o(result_o),
        .halt_o(halt_o), .pc_set_o(pc_set_o), .bus_cyc_o(bus_cyc_o),
        .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o),
        .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i),
        .bus_ack_i(bus_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] ir;
        logic [31:0] pc;
        logic [2:0]  ccr;
        logic [1:0]  rw;
        logic [31:0] res;
        logic        halt;
        logic        pcset;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc_cnt = 0;

    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every non-bubble output must match the oldest expected completion.
    always @(negedge clk_i) begin
        if (rst_i === 1'b0 && ir_o !== 64'h0) begin
            if (q.size() == 0) begin
                chk("unexpected_output", ir_o, 64'h0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ir_o", ir_o, e.ir);
                chk("pc_o", {32'h0, pc_o}, {32'h0, e.pc});
                chk("ccr_o", {61'h0, ccr_o}, {61'h0, e.ccr});
                chk("reg_write_o", {62'h0, reg_write_o}, {62'h0, e.rw});
                chk("result_o", {32'h0, result_o}, {32'h0, e.res});
                chk("halt_o", {63'h0, halt_o}, {63'h0, e.halt});
                chk("pc_set_o", {63'h0, pc_set_o}, {63'h0, e.pcset});
                chk("latency", 64'(cyc_cnt), 64'(e.cyc));
            end
        end
    end

    task automatic idle();
        ir_i = 64'h0; pc_i = 32'h0; ccr_i = 3'b000; reg_write_i = 2'b00;
        result_i = 32'h0; store_data_i = 32'h0; halt_i = 1'b0; pc_set_i = 1'b0;
        bus_ack_i = 1'b0; bus_dat_i = 32'h0;
        @(posedge clk_i); #1;
    endtask

    // Issue one instruction (called just after a posedge); returns just after the
    // posedge that completes it, so a following call is back-to-back.
    task automatic run_op(input string nm, input logic [63:0] ir, input logic [31:0] pc,
                          input logic [2:0] ccr, input logic [1:0] rw, input logic [31:0] res,
                          input logic [31:0] sd, input logic halt, input logic pcset,
                          input int k, input logic [31:0] rdata, input logic ack_noise,
                          input logic exp_we, input logic [3:0] exp_sel,
                          input logic [31:0] exp_dat, input logic [1:0] exp_rw,
                          input logic [31:0] exp_res);
        exp_t e;
        int stalls;
        ir_i = ir; pc_i = pc; ccr_i = ccr; reg_write_i = rw; result_i = res;
        store_data_i = sd; halt_i = halt; pc_set_i = pcset;
        e.ir = ir; e.pc = pc; e.ccr = ccr; e.rw = exp_rw; e.res = exp_res;
        e.halt = halt; e.pcset = pcset; e.cyc = cyc_cnt + 1 + k;
        q.push_back(e);
        if (k == 0) begin
            bus_ack_i = ack_noise;
            @(negedge clk_i);
            chk({nm, "_stall"}, {63'h0, stall_o}, 64'h0);
            chk({nm, "_cyc"}, {63'h0, bus_cyc_o}, 64'h0);
            @(posedge clk_i); #1;
            bus_ack_i = 1'b0;
        end else begin
            @(negedge clk_i);
            chk({nm, "_idle_stall"}, {63'h0, stall_o}, 64'h1);
            chk({nm, "_idle_cyc"}, {63'h0, bus_cyc_o}, 64'h0);
            stalls = (stall_o === 1'b1) ? 1 : 0;
            @(posedge clk_i); #1;
            for (int i = 1; i <= k; i++) begin
                if (i == k) begin
                    bus_ack_i = 1'b1;
                    bus_dat_i = rdata;
                end
                @(negedge clk_i);
                chk({nm, "_cyc"}, {62'h0, bus_cyc_o, bus_stb_o}, 64'h3);
                chk({nm, "_we"}, {63'h0, bus_we_o}, {63'h0, exp_we});
                chk({nm, "_sel"}, {60'h0, bus_sel_o}, {60'h0, exp_sel});
                chk({nm, "_adr"}, {32'h0, bus_adr_o}, {32'h0, res[31:2], 2'b00});
                if (exp_we) chk({nm, "_dat_o"}, {32'h0, bus_dat_o}, {32'h0, exp_dat});
                chk({nm, "_bubble"}, {ir_o, 29'h0, reg_write_o, halt_o}, 64'h0);
                if (i < k) begin
                    chk({nm, "_stall"}, {63'h0, stall_o}, 64'h1);
                    if (stall_o === 1'b1) stalls++;
                end else begin
                    chk({nm, "_ack_stall"}, {63'h0, stall_o}, 64'h0);
                end
                @(posedge clk_i); #1;
                bus_ack_i = 1'b0;
                bus_dat_i = 32'h0;
            end
            chk({nm, "_stall_cycles"}, 64'(stalls), 64'(k));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        ir_i = 64'h0; pc_i = 32'h0; ccr_i = 3'b000; reg_write_i = 2'b00;
        result_i = 32'h0; store_data_i = 32'h0; halt_i = 1'b0; pc_set_i = 1'b0;
        bus_ack_i = 1'b0; bus_dat_i = 32'h0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("reset_outs", {ir_o[31:0], result_o}, 64'h0);
        chk("reset_misc", {pc_o, 24'h0, ccr_o, reg_write_o, halt_o, pc_set_o, stall_o}, 64'h0);
        chk("reset_bus", {59'h0, bus_cyc_o, bus_stb_o, bus_we_o, 2'b00}, 64'h0);
        @(posedge clk_i); #1;

        // ALU passthrough, then ALU with flags and a stray ack outside BUS.
        run_op("alu", 64'h0000_0001_1A2B_3C4D, 32'h100, 3'b101, 2'b01, 32'h12345678, 32'h0,
               1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 2'b01, 32'h12345678);
        run_op("alu_flags", 64'h0000_0000_2300_0007, 32'h104, 3'b010, 2'b10, 32'hFFFF0000, 32'h0,
               1'b1, 1'b1, 0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 2'b10, 32'hFFFF0000);
        idle();

        run_op("ld_word", 64'h0000_0000_6030_0000, 32'h200, 3'b001, 2'b01, 32'h00001000, 32'h11223344,
               1'b0, 1'b0, 3, 32'hDEADBEEF, 1'b0, 1'b0, 4'hF, 32'h0, 2'b01, 32'hDEADBEEF);
        idle();
        run_op("ld_byte", 64'h0000_0000_6230_0000, 32'h204, 3'b000, 2'b01, 32'h00001002, 32'h11223344,
               1'b0, 1'b0, 2, 32'hAABBCCDD, 1'b0, 1'b0, 4'b0010, 32'h0, 2'b01, 32'h000000CC);
        idle();
        run_op("ld_half", 64'h0000_0000_6130_0000, 32'h208, 3'b000, 2'b10, 32'h00001002, 32'h11223344,
               1'b0, 1'b0, 1, 32'hAABBCCDD, 1'b0, 1'b0, 4'b0011, 32'h0, 2'b10, 32'h0000CCDD);
        idle();
        run_op("ld_sz3", 64'h0000_0000_6330_0000, 32'h20C, 3'b000, 2'b01, 32'h00004003, 32'h0,
               1'b0, 1'b0, 1, 32'h0BADF00D, 1'b0, 1'b0, 4'hF, 32'h0, 2'b01, 32'h0BADF00D);
        idle();
        run_op("st_byte", 64'h0000_0000_7250_0000, 32'h300, 3'b100, 2'b11, 32'h00002001, 32'h000000A5,
               1'b0, 1'b0, 2, 32'hFFFFFFFF, 1'b0, 1'b1, 4'b0100, 32'hA5A5A5A5, 2'b00, 32'h00002001);
        idle();
        run_op("st_half", 64'h0000_0000_7150_0000, 32'h304, 3'b000, 2'b01, 32'h00002000, 32'h0000BEEF,
               1'b0, 1'b0, 1, 32'h0, 1'b0, 1'b1, 4'b1100, 32'hBEEFBEEF, 2'b00, 32'h00002000);
        idle();

        // Back-to-back loads, ack in the first BUS cycle.
        run_op("b2b_1", 64'h0000_0000_6030_0000, 32'h400, 3'b001, 2'b01, 32'h00003000, 32'h0,
               1'b0, 1'b0, 1, 32'h01020304, 1'b0, 1'b0, 4'hF, 32'h0, 2'b01, 32'h01020304);
        run_op("b2b_2", 64'h0000_0000_6240_0000, 32'h404, 3'b010, 2'b01, 32'h00003003, 32'h0,
               1'b0, 1'b0, 1, 32'h11223344, 1'b0, 1'b0, 4'b0001, 32'h0, 2'b01, 32'h00000044);
        idle();
        idle();

        // Reset mid-BUS, then a late ack.
        ir_i = 64'h0000_0000_6030_0000; pc_i = 32'h500; reg_write_i = 2'b01; result_i = 32'h5000;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        ir_i = 64'h0; pc_i = 32'h0; reg_write_i = 2'b00; result_i = 32'h0;
        @(negedge clk_i);
        chk("rst_pre_cyc", {63'h0, bus_cyc_o}, 64'h1);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        bus_ack_i = 1'b1;
        bus_dat_i = 32'hCAFEBABE;
        @(negedge clk_i);
        chk("rst_cyc", {62'h0, bus_cyc_o, bus_stb_o}, 64'h0);
        chk("rst_outs", {ir_o[31:0], result_o}, 64'h0);
        chk("rst_misc", {pc_o, 27'h0, reg_write_o, halt_o, pc_set_o, 1'b0}, 64'h0);
        @(posedge clk_i); #1;
        bus_ack_i = 1'b0;
        @(negedge clk_i);
        chk("late_ack_outs", {ir_o[31:0], result_o}, 64'h0);
        chk("late_ack_rw", {62'h0, reg_write_o}, 64'h0);

        idle();
        idle();
        chk("queue_empty", 64'(q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
